// File: rtl/ami_channel_interleaver_pkg.sv
// Shared defaults and types for the AMI channel interleaver.
// Covers channel count, interleave granularity, queue depths and the queued op tag.
package ami_channel_interleaver_pkg;

    localparam int CHANNELS_PER_AMI = 4;
    localparam int AMI_ADDR_W       = 64;
    localparam int AMI_DATA_W       = 512;
    localparam int AMI_INTLV_SHIFT  = 6;
    localparam int AMI_Q_DEPTH      = 2;
    localparam int AMI_ORDER_DEPTH  = 16;

    typedef enum logic {
        AMI_OP_READ  = 1'b0,
        AMI_OP_WRITE = 1'b1
    } ami_op_e;

    // A single channel still needs a 1-bit select/index field.
    function automatic int ami_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ami_channel_interleaver_fifo.sv
// Synchronous FIFO with arbitrary depth, used for the per-channel request queues
// and the read-order queue. A full FIFO accepts a push in the cycle it is popped.
module ami_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ami_channel_interleaver.sv
// Splits an upstream request stream across address-interleaved memory channels
// and merges read responses back in global acceptance order.
module ami_channel_interleaver
    import ami_channel_interleaver_pkg::*;
#(
    parameter int NUM_CHANNELS = CHANNELS_PER_AMI,
    parameter int ADDR_W       = AMI_ADDR_W,
    parameter int DATA_W       = AMI_DATA_W,
    parameter int INTLV_SHIFT  = AMI_INTLV_SHIFT,
    parameter int Q_DEPTH      = AMI_Q_DEPTH,
    parameter int ORDER_DEPTH  = AMI_ORDER_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic                             req_is_write,
    input  logic [DATA_W-1:0]                req_data,
    output logic [NUM_CHANNELS-1:0]          ch_req_valid,
    input  logic [NUM_CHANNELS-1:0]          ch_req_ready,
    output logic [NUM_CHANNELS*ADDR_W-1:0]   ch_req_addr,
    output logic [NUM_CHANNELS-1:0]          ch_req_is_write,
    output logic [NUM_CHANNELS*DATA_W-1:0]   ch_req_data,
    input  logic [NUM_CHANNELS-1:0]          ch_resp_valid,
    output logic [NUM_CHANNELS-1:0]          ch_resp_ready,
    input  logic [NUM_CHANNELS*DATA_W-1:0]   ch_resp_data,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [DATA_W-1:0]                resp_data,
    output logic [$clog2(ORDER_DEPTH+1)-1:0] outstanding
);

    localparam int SEL_W    = ami_sel_w(NUM_CHANNELS);
    localparam int LOG2_N   = $clog2(NUM_CHANNELS);
    localparam int ENT_W    = 1 + ADDR_W + DATA_W;
    localparam int CH_CNT_W = $clog2(Q_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << INTLV_SHIFT) - ADDR_W'(1);

    logic [SEL_W-1:0]        tgt;
    logic [ADDR_W-1:0]       ch_addr;
    ami_op_e                 op;
    logic [ENT_W-1:0]        ch_entry;
    logic                    accept;
    logic                    tgt_can_push;

    logic [NUM_CHANNELS-1:0] ch_push, ch_pop, ch_full, ch_empty, ch_can_push;
    logic [ENT_W-1:0]        ch_head  [NUM_CHANNELS];
    logic [CH_CNT_W-1:0]     ch_count [NUM_CHANNELS];

    logic [SEL_W-1:0]        ord_head;
    logic                    ord_full, ord_empty, ord_push, ord_pop, ord_can_push;
    logic                    head_resp_valid;

    // Channel select comes from the interleave bits; removing them compacts the address.
    always_comb begin
        tgt     = (NUM_CHANNELS == 1) ? '0 : SEL_W'(req_addr >> INTLV_SHIFT);
        ch_addr = ((req_addr >> (INTLV_SHIFT + LOG2_N)) << INTLV_SHIFT) | (req_addr & LOW_MASK);
    end

    assign op       = req_is_write ? AMI_OP_WRITE : AMI_OP_READ;
    assign ch_entry = {op, ch_addr, req_data};

    always_comb begin
        tgt_can_push = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (tgt == SEL_W'(i)) tgt_can_push = ch_can_push[i];
        end
    end

    assign ord_can_push = ~ord_full | ord_pop;
    assign req_ready    = rst_n & tgt_can_push & (req_is_write | ord_can_push);
    assign accept       = req_valid & req_ready;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign ch_push[i]     = accept & (tgt == SEL_W'(i));
        assign ch_pop[i]      = ch_req_valid[i] & ch_req_ready[i];
        assign ch_can_push[i] = ~ch_full[i] | ch_pop[i];

        ami_fifo #(
            .WIDTH (ENT_W),
            .DEPTH (Q_DEPTH)
        ) u_ch_q (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (ch_push[i]),
            .push_data (ch_entry),
            .pop       (ch_pop[i]),
            .head_data (ch_head[i]),
            .full      (ch_full[i]),
            .empty     (ch_empty[i]),
            .count     (ch_count[i])
        );

        assign ch_req_valid[i]                  = ~ch_empty[i];
        assign ch_req_is_write[i]               = ch_head[i][ENT_W-1];
        assign ch_req_addr[i*ADDR_W +: ADDR_W]  = ch_head[i][DATA_W +: ADDR_W];
        assign ch_req_data[i*DATA_W +: DATA_W]  = ch_head[i][DATA_W-1:0];
        assign ch_resp_ready[i]                 = ~ord_empty & (ord_head == SEL_W'(i)) & resp_ready;

        always_ff @(posedge clk) begin
            if (rst_n) assert (ch_count[i] <= CH_CNT_W'(Q_DEPTH));
        end
    end

    // Read-order queue: the head channel index gates which response passes through.
    assign ord_push = accept & ~req_is_write;
    assign ord_pop  = resp_valid & resp_ready;

    ami_fifo #(
        .WIDTH (SEL_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ord_push),
        .push_data (tgt),
        .pop       (ord_pop),
        .head_data (ord_head),
        .full      (ord_full),
        .empty     (ord_empty),
        .count     (outstanding)
    );

    always_comb begin
        resp_data       = '0;
        head_resp_valid = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ord_head == SEL_W'(i)) begin
                resp_data       = ch_resp_data[i*DATA_W +: DATA_W];
                head_resp_valid = ch_resp_valid[i];
            end
        end
    end

    assign resp_valid = ~ord_empty & head_resp_valid;

endmodule

// File: tb/tb_ami_channel_interleaver.sv
// Bench for ami_channel_interleaver: directed scenarios plus a randomized run
// compared against a queue-based reference of the interleave/reorder rules.
module tb_ami_channel_interleaver;

    localparam int N   = 4;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int QD  = 2;
    localparam int OD  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid, req_ready, req_is_write;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_data;
    logic [N-1:0]    ch_req_valid, ch_req_ready, ch_req_is_write;
    logic [N*AW-1:0] ch_req_addr;
    logic [N*DW-1:0] ch_req_data;
    logic [N-1:0]    ch_resp_valid, ch_resp_ready;
    logic [N*DW-1:0] ch_resp_data;
    logic            resp_valid, resp_ready;
    logic [DW-1:0]   resp_data;
    logic [4:0]      outstanding;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } chreq_t;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] data;
    } rd_t;

    chreq_t        chq [N][$];
    logic [DW-1:0] rspq[N][$];
    rd_t           gq[$];

    ami_channel_interleaver #(
        .NUM_CHANNELS (N),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .INTLV_SHIFT  (6),
        .Q_DEPTH      (QD),
        .ORDER_DEPTH  (OD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_is_write    (req_is_write),
        .req_data        (req_data),
        .ch_req_valid    (ch_req_valid),
        .ch_req_ready    (ch_req_ready),
        .ch_req_addr     (ch_req_addr),
        .ch_req_is_write (ch_req_is_write),
        .ch_req_data     (ch_req_data),
        .ch_resp_valid   (ch_resp_valid),
        .ch_resp_ready   (ch_resp_ready),
        .ch_resp_data    (ch_resp_data),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .outstanding     (outstanding)
    );

    always #5 clk = ~clk;

    // Reference address arithmetic: 4 channels, 64-byte interleave.
    function automatic int exp_ch(input logic [AW-1:0] a);
        return int'((a / 64) % 4);
    endfunction

    function automatic logic [AW-1:0] exp_caddr(input logic [AW-1:0] a);
        return (a / 256) * 64 + (a % 64);
    endfunction

    function automatic logic [DW-1:0] rd_data(input int ch, input logic [AW-1:0] a);
        return a ^ (64'(ch) << 56) ^ 64'hC3A5_0F1E_5A3C_7700;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid     = 1'b0;
        req_addr      = '0;
        req_is_write  = 1'b0;
        req_data      = '0;
        ch_req_ready  = '0;
        ch_resp_valid = '0;
        ch_resp_data  = '0;
        resp_ready    = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
        req_valid    = 1'b1;
        req_addr     = a;
        req_is_write = wr;
        req_data     = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        send(64'h40, 1'b0, '0);
        #3;
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %0b want 0", req_ready); else passes++;
        checks++; if (ch_req_valid !== 4'b0) $display("FAIL reset_ch_req_valid got %b want 0000", ch_req_valid); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %0b want 0", resp_valid); else passes++;
        checks++; if (outstanding !== 5'd0) $display("FAIL reset_outstanding got %0d want 0", outstanding); else passes++;
        req_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #2;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %0b want 1", req_ready); else passes++;
        checks++; if (ch_req_valid !== 4'b0) $display("FAIL reset_release_ch_valid got %b want 0000", ch_req_valid); else passes++;
    endtask

    task automatic test_addr_map();
        logic [AW-1:0] addrs [3];
        int            chs   [3];
        logic [AW-1:0] caddr [3];
        addrs = '{64'h40, 64'hC0, 64'h100};
        chs   = '{1, 3, 0};
        caddr = '{64'h0, 64'h0, 64'h40};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            send(addrs[k], 1'b0, '0);
            #2;
            checks++; if (req_ready !== 1'b1) $display("FAIL map_ready[%0d] got %0b want 1", k, req_ready); else passes++;
            tick();
            req_valid = 1'b0;
            #1;
            checks++; if (ch_req_valid[chs[k]] !== 1'b1) $display("FAIL map_valid[%0d] ch%0d got %b", k, chs[k], ch_req_valid); else passes++;
            checks++; if (ch_req_addr[chs[k]*AW +: AW] !== caddr[k]) $display("FAIL map_addr[%0d] got %h want %h", k, ch_req_addr[chs[k]*AW +: AW], caddr[k]); else passes++;
            checks++; if (ch_req_is_write[chs[k]] !== 1'b0) $display("FAIL map_is_write[%0d] got 1 want 0", k); else passes++;
        end
        checks++; if (outstanding !== 5'd3) $display("FAIL map_outstanding got %0d want 3", outstanding); else passes++;
    endtask

    task automatic test_resp_order();
        logic [DW-1:0] d0, d2;
        d0 = 64'hD0D0_0000_1111_2222;
        d2 = 64'hD2D2_0000_3333_4444;
        apply_reset();
        ch_req_ready = 4'hF;
        send(64'h80, 1'b0, '0); tick();
        send(64'h00, 1'b0, '0); tick();
        req_valid = 1'b0;
        ch_resp_valid = 4'b0001;
        ch_resp_data[0 +: DW] = d0;
        resp_ready = 1'b1;
        #2;
        checks++; if (outstanding !== 5'd2) $display("FAIL order_outstanding got %0d want 2", outstanding); else passes++;
        for (int c = 0; c < 3; c++) begin
            checks++; if (resp_valid !== 1'b0) $display("FAIL order_hold[%0d] resp_valid got 1 want 0", c); else passes++;
            checks++; if (ch_resp_ready !== 4'b0100) $display("FAIL order_hold_ready[%0d] got %b want 0100", c, ch_resp_ready); else passes++;
            tick();
            #1;
        end
        ch_resp_valid = 4'b0101;
        ch_resp_data[2*DW +: DW] = d2;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== d2) $display("FAIL order_first got v=%0b %h want v=1 %h", resp_valid, resp_data, d2); else passes++;
        checks++; if (ch_resp_ready !== 4'b0100) $display("FAIL order_first_ready got %b want 0100", ch_resp_ready); else passes++;
        tick();
        ch_resp_valid = 4'b0001;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== d0) $display("FAIL order_second got v=%0b %h want v=1 %h", resp_valid, resp_data, d0); else passes++;
        checks++; if (ch_resp_ready !== 4'b0001) $display("FAIL order_second_ready got %b want 0001", ch_resp_ready); else passes++;
        tick();
        ch_resp_valid = 4'b0000;
        #1;
        checks++; if (resp_valid !== 1'b0 || outstanding !== 5'd0) $display("FAIL order_done got v=%0b out=%0d want v=0 out=0", resp_valid, outstanding); else passes++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d [3];
        d = '{64'hAAAA_0001, 64'hAAAA_0002, 64'hAAAA_0003};
        apply_reset();
        send(64'h040, 1'b1, d[0]); #2;
        checks++; if (req_ready !== 1'b1) $display("FAIL bp_first_ready got %0b want 1", req_ready); else passes++;
        tick();
        send(64'h140, 1'b1, d[1]); #2;
        checks++; if (req_ready !== 1'b1) $display("FAIL bp_second_ready got %0b want 1", req_ready); else passes++;
        tick();
        send(64'h240, 1'b1, d[2]); #2;
        checks++; if (req_ready !== 1'b0) $display("FAIL bp_third_stall got %0b want 0", req_ready); else passes++;
        tick();
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL bp_third_stall2 got %0b want 0", req_ready); else passes++;
        ch_req_ready[1] = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_return got %0b want 1", req_ready); else passes++;
        checks++; if (ch_req_addr[AW +: AW] !== exp_caddr(64'h040) || ch_req_data[DW +: DW] !== d[0]) $display("FAIL bp_head0 got %h/%h", ch_req_addr[AW +: AW], ch_req_data[DW +: DW]); else passes++;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (ch_req_valid[1] !== 1'b1 || ch_req_addr[AW +: AW] !== exp_caddr(64'h140) || ch_req_data[DW +: DW] !== d[1]) $display("FAIL bp_head1 got v=%0b %h/%h", ch_req_valid[1], ch_req_addr[AW +: AW], ch_req_data[DW +: DW]); else passes++;
        tick();
        #1;
        checks++; if (ch_req_valid[1] !== 1'b1 || ch_req_addr[AW +: AW] !== exp_caddr(64'h240) || ch_req_data[DW +: DW] !== d[2] || ch_req_is_write[1] !== 1'b1) $display("FAIL bp_head2 got v=%0b %h/%h", ch_req_valid[1], ch_req_addr[AW +: AW], ch_req_data[DW +: DW]); else passes++;
        tick();
        #1;
        checks++; if (ch_req_valid !== 4'b0 || outstanding !== 5'd0) $display("FAIL bp_drained got v=%b out=%0d want 0000/0", ch_req_valid, outstanding); else passes++;
    endtask

    task automatic test_order_full();
        apply_reset();
        ch_req_ready = 4'hF;
        for (int k = 0; k < OD; k++) begin
            send(64'(k) * 64, 1'b0, '0);
            #2;
            checks++; if (req_ready !== 1'b1) $display("FAIL full_fill_ready[%0d] got %0b want 1", k, req_ready); else passes++;
            tick();
        end
        req_valid = 1'b0;
        #2;
        checks++; if (outstanding !== 5'd16) $display("FAIL full_outstanding got %0d want 16", outstanding); else passes++;
        send(64'h40, 1'b0, '0); #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL full_read_ready got %0b want 0", req_ready); else passes++;
        req_is_write = 1'b1;
        req_data = 64'h5757;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL full_write_ready got %0b want 1", req_ready); else passes++;
        ch_req_ready = 4'h0;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 5'd16 || ch_req_valid[1] !== 1'b1 || ch_req_is_write[1] !== 1'b1) $display("FAIL full_write_accept got out=%0d v=%b", outstanding, ch_req_valid); else passes++;
        ch_req_ready = 4'hF;
        ch_resp_valid = 4'b0001;
        ch_resp_data[0 +: DW] = 64'hF00D;
        resp_ready = 1'b1;
        send(64'h80, 1'b0, '0);
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b1 || resp_data !== 64'hF00D) $display("FAIL full_push_at_pop got rdy=%0b rv=%0b %h", req_ready, resp_valid, resp_data); else passes++;
        tick();
        idle_inputs();
        #1;
        checks++; if (outstanding !== 5'd16) $display("FAIL full_after_swap got %0d want 16", outstanding); else passes++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        ch_req_ready = 4'hF;
        for (int k = 0; k < 5; k++) begin
            send(64'(k) * 64, 1'b0, '0);
            tick();
        end
        req_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 5'd5) $display("FAIL simul_pre got %0d want 5", outstanding); else passes++;
        send(64'h140, 1'b0, '0);
        ch_resp_valid = 4'b0001;
        ch_resp_data[0 +: DW] = 64'hBEEF;
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b1) $display("FAIL simul_both got rdy=%0b rv=%0b want 1/1", req_ready, resp_valid); else passes++;
        tick();
        idle_inputs();
        #1;
        checks++; if (outstanding !== 5'd5) $display("FAIL simul_post got %0d want 5", outstanding); else passes++;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        send(64'h00, 1'b0, '0); tick();
        send(64'h40, 1'b0, '0); tick();
        send(64'h80, 1'b0, '0); tick();
        req_valid = 1'b0;
        #1;
        checks++; if (ch_req_valid !== 4'b0111 || outstanding !== 5'd3) $display("FAIL mid_pre got v=%b out=%0d want 0111/3", ch_req_valid, outstanding); else passes++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (ch_req_valid !== 4'b0 || outstanding !== 5'd0) $display("FAIL mid_reset got v=%b out=%0d want 0000/0", ch_req_valid, outstanding); else passes++;
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) $display("FAIL mid_reset_hs got rdy=%0b rv=%0b want 0/0", req_ready, resp_valid); else passes++;
        tick();
        rst_n = 1'b1;
        ch_req_ready = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ch_req_valid !== 4'b0 || resp_valid !== 1'b0) $display("FAIL mid_stale[%0d] got v=%b rv=%0b", c, ch_req_valid, resp_valid); else passes++;
            tick();
        end
    endtask

    task automatic test_random();
        int            t, hc;
        logic          exp_rv, exp_rdy, ch_ok, ord_ok;
        logic [N-1:0]  exp_crr;
        chreq_t        e;
        apply_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            req_valid    = ($urandom_range(0, 99) < 60);
            req_addr     = {$urandom, $urandom};
            req_is_write = ($urandom_range(0, 2) == 0);
            req_data     = {$urandom, $urandom};
            resp_ready   = ($urandom_range(0, 99) < 70);
            for (int i = 0; i < N; i++) begin
                ch_req_ready[i] = ($urandom_range(0, 99) < 55);
                ch_resp_valid[i] = (rspq[i].size() > 0) && ($urandom_range(0, 99) < 60);
                ch_resp_data[i*DW +: DW] = (rspq[i].size() > 0) ? rspq[i][0] : {$urandom, $urandom};
            end
            #2;
            hc      = (gq.size() > 0) ? int'(gq[0].ch) : 0;
            exp_rv  = (gq.size() > 0) && ch_resp_valid[hc];
            exp_crr = (gq.size() > 0 && resp_ready) ? N'(1 << hc) : '0;
            checks++; if (resp_valid !== exp_rv) $display("FAIL rnd_resp_valid cyc %0d got %0b want %0b", cyc, resp_valid, exp_rv); else passes++;
            if (exp_rv) begin
                checks++; if (resp_data !== gq[0].data) $display("FAIL rnd_resp_data cyc %0d got %h want %h", cyc, resp_data, gq[0].data); else passes++;
            end
            checks++; if (ch_resp_ready !== exp_crr) $display("FAIL rnd_ch_resp_ready cyc %0d got %b want %b", cyc, ch_resp_ready, exp_crr); else passes++;
            checks++; if (int'(outstanding) != gq.size()) $display("FAIL rnd_outstanding cyc %0d got %0d want %0d", cyc, outstanding, gq.size()); else passes++;
            for (int i = 0; i < N; i++) begin
                checks++; if (ch_req_valid[i] !== (chq[i].size() > 0)) $display("FAIL rnd_ch_valid cyc %0d ch%0d got %0b want %0b", cyc, i, ch_req_valid[i], chq[i].size() > 0); else passes++;
                if (chq[i].size() > 0) begin
                    e = chq[i][0];
                    checks++; if (ch_req_addr[i*AW +: AW] !== e.addr || ch_req_is_write[i] !== e.wr || (e.wr && ch_req_data[i*DW +: DW] !== e.data)) $display("FAIL rnd_ch_head cyc %0d ch%0d got %h/%0b want %h/%0b", cyc, i, ch_req_addr[i*AW +: AW], ch_req_is_write[i], e.addr, e.wr); else passes++;
                end
            end
            t       = exp_ch(req_addr);
            ch_ok   = (chq[t].size() < QD) || (ch_req_ready[t] && chq[t].size() > 0);
            ord_ok  = req_is_write || (gq.size() < OD) || (exp_rv && resp_ready);
            exp_rdy = ch_ok && ord_ok;
            checks++; if (req_ready !== exp_rdy) $display("FAIL rnd_req_ready cyc %0d got %0b want %0b", cyc, req_ready, exp_rdy); else passes++;
            if (exp_rv && resp_ready) begin
                void'(gq.pop_front());
                void'(rspq[hc].pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (chq[i].size() > 0 && ch_req_ready[i]) begin
                    e = chq[i].pop_front();
                    if (!e.wr) rspq[i].push_back(rd_data(i, ch_req_addr[i*AW +: AW]));
                end
            end
            if (req_valid && exp_rdy) begin
                chq[t].push_back('{wr: req_is_write, addr: exp_caddr(req_addr), data: req_data});
                if (!req_is_write) gq.push_back('{ch: 2'(t), data: rd_data(t, exp_caddr(req_addr))});
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_addr_map();
        test_resp_order();
        test_backpressure();
        test_order_full();
        test_simultaneous();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
